// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read-channel arbiter. Instruction cache is index 0 and data cache is
// index 1. Only one burst is in flight at a time: the block arbitrates, issues AR, and
// then routes R beats back to the granted requester.
module axi_read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [1:0]              req_arvalid_i,
  input  logic [2*ADDR_WIDTH-1:0] req_araddr_i,
  input  logic [15:0]             req_arlen_i,
  input  logic [5:0]              req_arsize_i,
  input  logic [3:0]              req_arburst_i,
  output logic [1:0]              req_arready_o,
  output logic [1:0]              req_rvalid_o,
  output logic [DATA_WIDTH-1:0]   req_rdata_o,
  output logic [1:0]              req_rlast_o,
  input  logic [1:0]              req_rready_i,
  output logic                    m_axi_arvalid_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr_o,
  output logic [7:0]              m_axi_arlen_o,
  output logic [2:0]              m_axi_arsize_o,
  output logic [1:0]              m_axi_arburst_o,
  input  logic                    m_axi_arready_i,
  input  logic                    m_axi_rvalid_i,
  input  logic                    m_axi_rlast_i,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata_i,
  output logic                    m_axi_rready_o,
  output logic                    grant_o,
  output logic                    busy_o,
  output logic                    burst_error_o
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                  state_q;
  logic                    grant_q;
  logic                    last_grant_q;
  logic                    busy_q;
  logic                    burst_error_q;
  logic                    arvalid_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [7:0]              arlen_q;
  logic [2:0]              arsize_q;
  logic [1:0]              arburst_q;
  logic [7:0]              beat_cnt_q;
  logic                    winner;
  logic                    beat;

  // Round-robin winner: a lone requester wins outright, a tie goes away from last_grant.
  always_comb begin
    winner = 1'b0;
    case (req_arvalid_i)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant_q;
      default: winner = 1'b0;
    endcase
  end

  // Combinational AR acknowledge and R-channel routing toward the granted requester.
  always_comb begin
    req_arready_o  = 2'b00;
    req_rvalid_o   = 2'b00;
    req_rlast_o    = 2'b00;
    m_axi_rready_o = 1'b0;
    if (state_q == StAddr && m_axi_arready_i) begin
      req_arready_o[grant_q] = 1'b1;
    end
    if (state_q == StData) begin
      req_rvalid_o[grant_q] = m_axi_rvalid_i;
      req_rlast_o[grant_q]  = m_axi_rlast_i;
      m_axi_rready_o        = req_rready_i[grant_q];
    end
  end

  assign beat = (state_q == StData) && m_axi_rvalid_i && m_axi_rready_o;

  // Burst sequencer with registered AR fields, grant, busy and error pulse.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      busy_q        <= 1'b0;
      burst_error_q <= 1'b0;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      arlen_q       <= 8'd0;
      arsize_q      <= 3'd0;
      arburst_q     <= 2'd0;
      beat_cnt_q    <= 8'd0;
    end else begin
      burst_error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req_arvalid_i) begin
            grant_q   <= winner;
            araddr_q  <= winner ? req_araddr_i[ADDR_WIDTH +: ADDR_WIDTH]
                                : req_araddr_i[0 +: ADDR_WIDTH];
            arlen_q   <= winner ? req_arlen_i[15:8] : req_arlen_i[7:0];
            arsize_q  <= winner ? req_arsize_i[5:3] : req_arsize_i[2:0];
            arburst_q <= winner ? req_arburst_i[3:2] : req_arburst_i[1:0];
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          if (m_axi_arready_i) begin
            arvalid_q  <= 1'b0;
            beat_cnt_q <= 8'd0;
            state_q    <= StData;
          end
        end
        StData: begin
          if (beat) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (m_axi_rlast_i) begin
              state_q      <= StIdle;
              busy_q       <= 1'b0;
              last_grant_q <= grant_q;
              // An overrun already flagged itself when it passed arlen; only a short
              // burst is reported here so each bad burst pulses once.
              burst_error_q <= (beat_cnt_q < arlen_q);
            end else if (beat_cnt_q == arlen_q) begin
              burst_error_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_rdata_o     = m_axi_rdata_i;
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_araddr_o  = araddr_q;
  assign m_axi_arlen_o   = arlen_q;
  assign m_axi_arsize_o  = arsize_q;
  assign m_axi_arburst_o = arburst_q;
  assign grant_o         = grant_q;
  assign busy_o          = busy_q;
  assign burst_error_o   = burst_error_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: a table of directed bursts, a mid-burst reset sequence and
// randomized bursts checked against a round-robin / beat-count reference model.
module tb_axi_read_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_arvalid;
  logic [2*AW-1:0] req_araddr;
  logic [15:0]     req_arlen;
  logic [5:0]      req_arsize;
  logic [3:0]      req_arburst;
  logic [1:0]      req_arready;
  logic [1:0]      req_rvalid;
  logic [DW-1:0]   req_rdata;
  logic [1:0]      req_rlast;
  logic [1:0]      req_rready;
  logic            m_axi_arvalid;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic            m_axi_arready;
  logic            m_axi_rvalid;
  logic            m_axi_rlast;
  logic [DW-1:0]   m_axi_rdata;
  logic            m_axi_rready;
  logic            grant;
  logic            busy;
  logic            burst_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_read_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .req_arvalid_i  (req_arvalid),
    .req_araddr_i   (req_araddr),
    .req_arlen_i    (req_arlen),
    .req_arsize_i   (req_arsize),
    .req_arburst_i  (req_arburst),
    .req_arready_o  (req_arready),
    .req_rvalid_o   (req_rvalid),
    .req_rdata_o    (req_rdata),
    .req_rlast_o    (req_rlast),
    .req_rready_i   (req_rready),
    .m_axi_arvalid_o(m_axi_arvalid),
    .m_axi_araddr_o (m_axi_araddr),
    .m_axi_arlen_o  (m_axi_arlen),
    .m_axi_arsize_o (m_axi_arsize),
    .m_axi_arburst_o(m_axi_arburst),
    .m_axi_arready_i(m_axi_arready),
    .m_axi_rvalid_i (m_axi_rvalid),
    .m_axi_rlast_i  (m_axi_rlast),
    .m_axi_rdata_i  (m_axi_rdata),
    .m_axi_rready_o (m_axi_rready),
    .grant_o        (grant),
    .busy_o         (busy),
    .burst_error_o  (burst_error)
  );

  typedef struct {
    logic [1:0] mask;
    int         delay;
    logic [7:0] len;
    int         nbeats;
    int         stall;
    int         gap;
    int         exp_grant;
    bit         exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_arvalid"}, m_axi_arvalid, 0);
    chk({tag, "_araddr"}, m_axi_araddr, 0);
    chk({tag, "_arlen"}, m_axi_arlen, 0);
    chk({tag, "_arsize"}, m_axi_arsize, 0);
    chk({tag, "_arburst"}, m_axi_arburst, 0);
    chk({tag, "_rready"}, m_axi_rready, 0);
    chk({tag, "_req_rvalid"}, req_rvalid, 0);
    chk({tag, "_req_rlast"}, req_rlast, 0);
    chk({tag, "_req_arready"}, req_arready, 0);
    chk({tag, "_burst_error"}, burst_error, 0);
  endtask

  // Called right after an active edge with the DUT idle; returns the same way.
  task automatic run_burst(input logic [1:0] mask, input int delay, input logic [7:0] len,
                           input int nbeats, input int stall, input int gap, input int abort,
                           input int exp_g, output bit err_seen);
    logic [1:0]    oh;
    logic [AW-1:0] exp_addr;
    bit            exp_err;
    oh       = 2'b01 << exp_g;
    err_seen = 1'b0;
    req_arvalid = mask;
    req_araddr  = {{$urandom, $urandom}, {$urandom, $urandom}} & ~{2{64'h3f}};
    req_arlen[exp_g*8 +: 8]       = len;
    req_arlen[(1-exp_g)*8 +: 8]   = len ^ 8'h5a;
    req_arsize  = {3'd3, 3'd2};
    req_arburst = {2'd1, 2'd2};
    exp_addr    = req_araddr[exp_g*AW +: AW];
    @(posedge clk); #1;
    m_axi_arready = (delay == 0);
    @(negedge clk);
    chk("ar_latency", m_axi_arvalid, 1);
    chk("grant", grant, exp_g);
    chk("busy_addr", busy, 1);
    chk("arlen", m_axi_arlen, len);
    chk("arsize", m_axi_arsize, exp_g ? 3 : 2);
    chk("arburst", m_axi_arburst, exp_g ? 1 : 2);
    for (int k = 0; k <= delay; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        m_axi_arready = (k == delay);
        @(negedge clk);
      end
      chk("arvalid_hold", m_axi_arvalid, 1);
      chk("araddr_hold", m_axi_araddr, exp_addr);
      chk("req_arready", req_arready, (k == delay) ? oh : 2'b00);
    end
    @(posedge clk); #1;
    m_axi_arready = 1'b0;
    req_arvalid   = req_arvalid & ~oh;
    req_rready    = 2'b11;
    for (int i = 0; i < nbeats; i++) begin
      if (i == abort) begin
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b0;
        rst          = 1'b1;
        @(posedge clk); #1;
        check_all_zero("mid_reset");
        rst          = 1'b0;
        m_axi_rvalid = 1'b0;
        req_arvalid  = 2'b00;
        return;
      end
      if (i == gap) begin
        m_axi_rvalid = 1'b0;
        req_rready   = 2'b11;
        @(negedge clk);
        chk("gap_rvalid", req_rvalid, 0);
        chk("gap_rready", m_axi_rready, 1);
        @(posedge clk); #1;
        chk("gap_err", burst_error, 0);
      end
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = (i == nbeats - 1);
      m_axi_rdata  = {$urandom, $urandom};
      if (i == stall) begin
        req_rready = ~oh;
        @(negedge clk);
        chk("stall_rready", m_axi_rready, 0);
        chk("stall_rvalid", req_rvalid, oh);
        @(posedge clk); #1;
        chk("stall_err", burst_error, 0);
        chk("stall_busy", busy, 1);
      end
      req_rready = (i % 2 == 1) ? 2'b11 : oh;
      @(negedge clk);
      chk("rready", m_axi_rready, 1);
      chk("rvalid_route", req_rvalid, oh);
      chk("rlast_route", req_rlast, m_axi_rlast ? oh : 2'b00);
      chk("rdata", req_rdata, m_axi_rdata);
      chk("busy_data", busy, 1);
      @(posedge clk); #1;
      exp_err = (i == nbeats - 1) ? (i < int'(len)) : (i == int'(len));
      chk("burst_error", burst_error, exp_err);
      if (burst_error) err_seen = 1'b1;
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    chk("busy_end", busy, 0);
    chk("arvalid_end", m_axi_arvalid, 0);
  endtask

  initial begin
    vec_t       tbl[6];
    bit         es;
    int         last;
    logic [1:0] pend;
    int         g;
    logic [7:0] len;
    int         nb;
    int         stall;
    int         gap;

    tbl[0] = '{2'b11, 0, 8'd7, 8, -1, -1, 0, 1'b0};
    tbl[1] = '{2'b10, 5, 8'd7, 8, -1,  2, 1, 1'b0};
    tbl[2] = '{2'b11, 0, 8'd7, 8,  3, -1, 0, 1'b0};
    tbl[3] = '{2'b11, 2, 8'd7, 6, -1, -1, 1, 1'b1};
    tbl[4] = '{2'b01, 1, 8'd3, 6,  2, -1, 0, 1'b1};
    tbl[5] = '{2'b10, 0, 8'd0, 1,  0, -1, 1, 1'b0};

    rst = 1'b1;
    req_arvalid = 2'b00;
    req_araddr = '0;
    req_arlen = '0;
    req_arsize = '0;
    req_arburst = '0;
    req_rready = 2'b11;
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    m_axi_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    for (int r = 0; r < 6; r++) begin
      run_burst(tbl[r].mask, tbl[r].delay, tbl[r].len, tbl[r].nbeats, tbl[r].stall,
                tbl[r].gap, -1, tbl[r].exp_grant, es);
      chk("row_error", es, tbl[r].exp_err);
    end

    // Reset after three beats of a req0 burst; model restarts from reset state.
    run_burst(2'b01, 0, 8'd7, 8, -1, -1, 3, 0, es);
    last = 1;
    pend = 2'b00;

    for (int n = 0; n < 60; n++) begin
      pend = pend | 2'($urandom_range(0, 3));
      if (pend == 2'b00) pend = 2'($urandom_range(1, 3));
      g = (pend == 2'b11) ? 1 - last : (pend[1] ? 1 : 0);
      case ($urandom_range(0, 4))
        0:       len = 8'd0;
        1:       len = 8'd1;
        2:       len = 8'd3;
        3:       len = 8'd7;
        default: len = 8'd15;
      endcase
      nb = int'(len) + 1;
      case ($urandom_range(0, 5))
        0:       nb = 1 + $urandom_range(0, int'(len));
        1:       nb = int'(len) + 1 + $urandom_range(1, 3);
        default: ;
      endcase
      stall = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
      gap   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
      run_burst(pend, $urandom_range(0, 3), len, nb, stall, gap, -1, g, es);
      chk("rand_error", es, (nb - 1) != int'(len));
      last = g;
      pend[g] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
